// File: rtl/divide_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// Fixed latency: Done arrives N+2 cycles after the accepting cycle, for any operands.
module divide_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Signed,
  input  logic        Rem,
  input  logic        ExtWord,
  output logic [63:0] Y,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic [63:0] dvd_q, dvs_q, rem_q, quo_q, y_q;
  logic [5:0]  cnt_q;
  logic        qneg_q, rneg_q, rsel_q, word_q, busy_q, done_q;

  // Operand conditioning at Start: signs, magnitudes, divisor-zero detect.
  logic        sa, sb, bz;
  logic [63:0] a_ld, b_ld, a_neg, b_neg, a_mag, b_mag, dvd_d;

  always_comb begin
    a_ld  = ExtWord ? {32'd0, A[31:0]} : A;
    b_ld  = ExtWord ? {32'd0, B[31:0]} : B;
    sa    = Signed & (ExtWord ? A[31] : A[63]);
    sb    = Signed & (ExtWord ? B[31] : B[63]);
    bz    = (b_ld == 64'd0);
    a_neg = 64'd0 - a_ld;
    b_neg = 64'd0 - b_ld;
    a_mag = sa ? (ExtWord ? {32'd0, a_neg[31:0]} : a_neg) : a_ld;
    b_mag = sb ? (ExtWord ? {32'd0, b_neg[31:0]} : b_neg) : b_ld;
    // W dividends are left-justified so the step always consumes bit 63.
    dvd_d = ExtWord ? {a_mag[31:0], 32'd0} : a_mag;
  end

  // One restoring step. rem_q < divisor holds, so the partial remainder
  // after a successful subtract always fits back into 64 bits.
  logic [64:0] trial;
  logic [63:0] diff, rem_d, quo_d;
  logic        ge;

  always_comb begin
    trial = {rem_q, dvd_q[63]};
    ge    = (trial >= {1'b0, dvs_q});
    diff  = trial[63:0] - dvs_q;
    rem_d = ge ? diff : trial[63:0];
    quo_d = {quo_q[62:0], ge};
  end

  // Sign fix-up, result select and W sign-extension.
  logic [63:0] qf, rf, res, y_d;

  always_comb begin
    qf  = qneg_q ? (64'd0 - quo_q) : quo_q;
    rf  = rneg_q ? (64'd0 - rem_q) : rem_q;
    res = rsel_q ? rf : qf;
    y_d = word_q ? {{32{res[31]}}, res[31:0]} : res;
  end

  logic [5:0] last;
  assign last = word_q ? 6'd31 : 6'd63;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rsel_q  <= 1'b0;
      word_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            dvd_q   <= dvd_d;
            dvs_q   <= b_mag;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            // Divide-by-zero keeps the all-ones quotient un-negated.
            qneg_q  <= (sa ^ sb) & ~bz;
            rneg_q  <= sa;
            rsel_q  <= Rem;
            word_q  <= ExtWord;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          dvd_q <= {dvd_q[62:0], 1'b0};
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == last) state_q <= FIX;
        end
        FIX: begin
          y_q     <= y_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Y    = y_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_divide_unit.sv
// Directed + random checks of divide_unit against an arithmetic reference model.
module tb_divide_unit;

  logic        clk = 1'b0;
  logic        reset, Start, Signed, Rem, ExtWord;
  logic [63:0] A, B, Y;
  logic        Busy, Done;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  divide_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .A(A), .B(B),
    .Signed(Signed), .Rem(Rem), .ExtWord(ExtWord),
    .Y(Y), .Busy(Busy), .Done(Done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference: plain language-level division with the ISA corner cases.
  function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                          input logic s, input logic r, input logic w);
    logic [31:0] a32, b32, q32, r32, p32;
    logic [63:0] q64, r64;
    int          ia, ib;
    longint      la, lb;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      ia  = a32;
      ib  = b32;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (s) begin
        q32 = ia / ib; r32 = ia % ib;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      p32 = r ? r32 : q32;
      return {{32{p32[31]}}, p32};
    end
    la = a;
    lb = b;
    if (b == 64'd0) begin
      q64 = '1; r64 = a;
    end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = 64'd0;
    end else if (s) begin
      q64 = la / lb; r64 = la % lb;
    end else begin
      q64 = a / b; r64 = a % b;
    end
    return r ? r64 : q64;
  endfunction

  // Issues one operation in the current cycle and follows it to Done.
  // glitch=1 pulses a second Start with other operands mid-CALC.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic r, input logic w, input string tag, input bit glitch);
    logic [63:0] exp;
    int          k, lat;
    exp = ref_div(a, b, s, r, w);
    lat = w ? 34 : 66;
    Start = 1'b1; A = a; B = b; Signed = s; Rem = r; ExtWord = w;
    tick;
    Start = 1'b0; A = rnd64(); B = rnd64();
    Signed = 1'($urandom); Rem = 1'($urandom); ExtWord = 1'($urandom);
    check({tag, " busy"}, 64'(Busy), 64'd1);
    k = 1;
    while (!Done && k < 200) begin
      if (glitch && k == 5) begin
        Start = 1'b1; A = rnd64(); B = 64'd3;
      end
      tick;
      Start = 1'b0;
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(lat));
    check({tag, " Y"}, Y, exp);
    tick;
    check({tag, " done-pulse"}, {62'd0, Busy, Done}, 64'd0);
    check({tag, " Y-hold"}, Y, exp);
  endtask

  initial begin
    int dcnt;
    logic [63:0] ra, rb;
    reset = 1'b1; Start = 1'b0; A = '0; B = '0; Signed = 0; Rem = 0; ExtWord = 0;
    tick; tick;
    check("reset Y", Y, 64'd0);
    check("reset Busy/Done", {62'd0, Busy, Done}, 64'd0);

    // Reset wins over a simultaneous Start.
    Start = 1'b1; A = 64'd100; B = 64'd7;
    tick;
    reset = 1'b0; Start = 1'b0;
    check("rst-prio busy0", 64'(Busy), 64'd0);
    tick;
    check("rst-prio busy1", 64'(Busy), 64'd0);

    run_op(64'd100, 64'd7, 0, 0, 0, "100/7 q", 0);
    run_op(64'd100, 64'd7, 0, 1, 0, "100/7 r", 0);
    run_op(-64'sd7, 64'd2, 1, 0, 0, "-7/2 q", 0);
    run_op(-64'sd7, 64'd2, 1, 1, 0, "-7/2 r", 0);
    run_op(64'h1234, 64'd0, 0, 0, 0, "div0 q", 0);
    run_op(64'h1234, 64'd0, 0, 1, 0, "div0 r", 0);
    run_op(-64'sd5, 64'd0, 1, 0, 0, "sdiv0 q", 0);
    run_op(-64'sd5, 64'd0, 1, 1, 0, "sdiv0 r", 0);
    run_op(64'h8000_0000_0000_0000, '1, 1, 0, 0, "ovf q", 0);
    run_op(64'h8000_0000_0000_0000, '1, 1, 1, 0, "ovf r", 0);
    run_op(64'hFFFF_FFFF_0000_0000, 64'd1, 0, 0, 1, "W lo0", 0);
    run_op(64'h0000_0000_FFFF_FFFE, 64'd1, 0, 0, 1, "W fffe", 0);
    run_op(64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1, 0, 1, "W ovf q", 0);
    run_op(64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0000, 1, 1, 1, "W div0 r", 0);
    run_op(64'd1000, 64'd9, 0, 0, 0, "glitch", 1);

    // Reset ten cycles into CALC aborts the operation silently.
    Start = 1'b1; A = 64'd999; B = 64'd4; Signed = 0; Rem = 0; ExtWord = 0;
    tick;
    Start = 1'b0;
    repeat (10) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort Busy/Done", {62'd0, Busy, Done}, 64'd0);
    check("abort Y", Y, 64'd0);
    dcnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick;
      if (Done) dcnt++;
    end
    check("abort no-done", 64'(dcnt), 64'd0);
    run_op(64'd77, 64'd5, 0, 1, 0, "post-abort", 0);

    for (int i = 0; i < 40; i++) begin
      ra = rnd64();
      case ($urandom_range(3))
        0: rb = 64'($urandom_range(15));
        1: rb = -64'($urandom_range(15));
        2: rb = {32'd0, $urandom};
        default: rb = rnd64();
      endcase
      run_op(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), "random", 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
